// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - HUB75-style two-half LED matrix row scan driver
// Optional per-row on-time limit enabled by defining MATRIX_BRIGHTNESS_EN.
module matrix_scan_driver #(
    parameter int OE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] row_0,
    input  logic [63:0] row_1,
`ifdef MATRIX_BRIGHTNESS_EN
    input  logic [7:0]  brightness,
`endif
    output logic        r_enable,
    output logic [5:0]  row_0_sel,
    output logic [5:0]  row_1_sel,
    output logic        get_buffer,
    output logic        led_top,
    output logic        led_bot,
    output logic        led_clk,
    output logic        latch,
    output logic        oe_n,
    output logic [4:0]  addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DISPLAY,
        S_NEXT
    } state_t;

    localparam logic [7:0] OE_LAST    = 8'(OE_CYCLES - 1);
    localparam logic [7:0] SHIFT_LAST = 8'd127;
    localparam logic [7:0] LOAD_LAST  = 8'd1;

    state_t      state;
    state_t      state_next;
    logic [7:0]  tick;
    logic [4:0]  cnt;
    logic [63:0] sr_top;
    logic [63:0] sr_bot;

`ifdef MATRIX_BRIGHTNESS_EN
    logic [7:0]  on_limit;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (enable) state_next = S_FETCH;
            S_FETCH:   state_next = S_LOAD;
            // Two LOAD cycles: the first covers the memory read latency, the
            // second captures with data settled, giving a 133+OE_CYCLES row.
            S_LOAD:    if (tick == LOAD_LAST) state_next = S_SHIFT;
            S_SHIFT:   if (tick == SHIFT_LAST) state_next = S_LATCH;
            S_LATCH:   state_next = S_DISPLAY;
            S_DISPLAY: if (tick == OE_LAST) state_next = S_NEXT;
            S_NEXT:    state_next = enable ? S_FETCH : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            tick   <= '0;
            cnt    <= '0;
            addr   <= '0;
            sr_top <= '0;
            sr_bot <= '0;
        end else begin
            state <= state_next;
            tick  <= (state_next != state) ? 8'd0 : tick + 8'd1;
            if (state == S_LOAD && state_next == S_SHIFT) begin
                sr_top <= row_0;
                sr_bot <= row_1;
            end else if (state == S_SHIFT && tick[0]) begin
                sr_top <= {sr_top[62:0], 1'b0};
                sr_bot <= {sr_bot[62:0], 1'b0};
            end
            // Row address moves while still blanked, visible during LATCH.
            if (state == S_SHIFT && state_next == S_LATCH)
                addr <= cnt;
            if (state == S_NEXT)
                cnt <= cnt + 5'd1;
        end
    end

`ifdef MATRIX_BRIGHTNESS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            on_limit <= '0;
        else if (state == S_LATCH)
            on_limit <= (brightness < 8'(OE_CYCLES)) ? brightness : 8'(OE_CYCLES);
    end
`endif

    always_comb begin
        row_0_sel  = {1'b0, cnt};
        row_1_sel  = {1'b1, cnt};
        r_enable   = (state == S_FETCH);
        get_buffer = (state == S_NEXT) && (cnt == 5'd31);
        led_clk    = (state == S_SHIFT) && tick[0];
        led_top    = (state == S_SHIFT) && sr_top[63];
        led_bot    = (state == S_SHIFT) && sr_bot[63];
        latch      = (state == S_LATCH);
`ifdef MATRIX_BRIGHTNESS_EN
        oe_n       = !((state == S_DISPLAY) && (tick < on_limit));
`else
        oe_n       = (state != S_DISPLAY);
`endif
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - directed/randomized bench for matrix_scan_driver
module tb_matrix_scan_driver;

    localparam int OE_CYCLES  = 64;
    localparam int ROW_PERIOD = 133 + OE_CYCLES;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [63:0] row_0;
    logic [63:0] row_1;
    logic        r_enable;
    logic [5:0]  row_0_sel;
    logic [5:0]  row_1_sel;
    logic        get_buffer;
    logic        led_top;
    logic        led_bot;
    logic        led_clk;
    logic        latch;
    logic        oe_n;
    logic [4:0]  addr;
`ifdef MATRIX_BRIGHTNESS_EN
    logic [7:0]  brightness;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int overlap = 0;
    int fetch_t[$];
    int gb_t[$];
    logic [63:0] mem [64];
    logic [5:0]  s0;
    logic [5:0]  s1;

    matrix_scan_driver #(.OE_CYCLES(OE_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .row_0      (row_0),
        .row_1      (row_1),
`ifdef MATRIX_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .r_enable   (r_enable),
        .row_0_sel  (row_0_sel),
        .row_1_sel  (row_1_sel),
        .get_buffer (get_buffer),
        .led_top    (led_top),
        .led_bot    (led_bot),
        .led_clk    (led_clk),
        .latch      (latch),
        .oe_n       (oe_n),
        .addr       (addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (r_enable === 1'b1) fetch_t.push_back(cyc);
            if (get_buffer === 1'b1) gb_t.push_back(cyc);
            if (r_enable === 1'b1 && get_buffer === 1'b1) overlap++;
        end
    end

    // Frame memory: the selects seen with r_enable are answered after the next edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && r_enable === 1'b1) begin
            s0 = row_0_sel;
            s1 = row_1_sel;
            @(posedge clk);
            #1;
            row_0 = mem[s0];
            row_1 = mem[s1];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input int row, input int drop_at, input int rst_at);
        int          guard;
        int          edges;
        int          bad;
        int          on_cnt;
        int          exp_on;
        logic [63:0] top;
        logic [63:0] bot;
        logic        pclk;
        logic        ptop;
        logic        pbot;
`ifdef MATRIX_BRIGHTNESS_EN
        brightness = (row == 9 || row == 10) ? 8'd16 :
                     (row == 2) ? 8'd0 : 8'($urandom_range(0, 90));
        exp_on = (int'(brightness) < OE_CYCLES) ? int'(brightness) : OE_CYCLES;
`else
        exp_on = OE_CYCLES;
`endif
        guard = 0;
        while (r_enable !== 1'b1 && guard < 2 * ROW_PERIOD) begin
            @(negedge clk);
            guard++;
        end
        check("fetch_seen", 64'(r_enable), 64'd1);
        check("row_0_sel", 64'(row_0_sel), 64'(row));
        check("row_1_sel", 64'(row_1_sel), 64'(row + 32));
        top = '0; bot = '0; edges = 0; bad = 0;
        pclk = 1'b0; ptop = 1'b0; pbot = 1'b0; guard = 0;
        @(negedge clk);
        while (latch !== 1'b1 && guard < 400) begin
            if (guard == drop_at) enable = 1'b0;
            if (led_clk === 1'b1 && pclk === 1'b0) begin
                top = {top[62:0], led_top};
                bot = {bot[62:0], led_bot};
                edges++;
                if (led_top !== ptop || led_bot !== pbot) bad++;
            end
            if (oe_n !== 1'b1 || r_enable !== 1'b0) bad++;
            pclk = led_clk; ptop = led_top; pbot = led_bot;
            @(negedge clk);
            guard++;
        end
        check("latch_seen", 64'(latch), 64'd1);
        check("latch_addr", 64'(addr), 64'(row));
        check("latch_oe_n", 64'(oe_n), 64'd1);
        check("led_clk_edges", 64'(edges), 64'd64);
        check("led_top_bits", top, mem[row]);
        check("led_bot_bits", bot, mem[row + 32]);
        check("shift_stable_blanked", 64'(bad), 64'd0);
        on_cnt = 0;
        for (int i = 0; i < OE_CYCLES + 2; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                reset = 1'b0;
                #1;
                check("rst_oe_n", 64'(oe_n), 64'd1);
                check("rst_addr", 64'(addr), 64'd0);
                check("rst_sel", 64'(row_0_sel), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (oe_n === 1'b0) on_cnt++;
        end
        check("display_on_cycles", 64'(on_cnt), 64'(exp_on));
    endtask

    initial begin
        int bad;
        int nf;
        reset  = 1'b0;
        enable = 1'b0;
        row_0  = '0;
        row_1  = '0;
`ifdef MATRIX_BRIGHTNESS_EN
        brightness = 8'd0;
`endif
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
        mem[0]  = 64'h8000_0000_0000_0001;
        mem[32] = ~mem[0];

        repeat (3) @(negedge clk);
        check("rst_r_enable", 64'(r_enable), 64'd0);
        check("rst_get_buffer", 64'(get_buffer), 64'd0);
        check("rst_led_top", 64'(led_top), 64'd0);
        check("rst_led_bot", 64'(led_bot), 64'd0);
        check("rst_led_clk", 64'(led_clk), 64'd0);
        check("rst_latch", 64'(latch), 64'd0);
        check("rst_oe_n0", 64'(oe_n), 64'd1);
        check("rst_addr0", 64'(addr), 64'd0);
        check("rst_row_0_sel", 64'(row_0_sel), 64'd0);
        check("rst_row_1_sel", 64'(row_1_sel), 64'd32);

        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (r_enable !== 1'b0 || oe_n !== 1'b1 || latch !== 1'b0) bad++;
        end
        check("idle_hold", 64'(bad), 64'd0);

        enable = 1'b1;
        @(negedge clk);
        check("first_fetch_latency", 64'(r_enable), 64'd1);

        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 32; r++)
                check_row(r, -1, -1);
        #1;
        check("fetch_count", 64'(fetch_t.size()), 64'd65);
        bad = 0;
        for (int i = 1; i < fetch_t.size(); i++)
            if (fetch_t[i] - fetch_t[i - 1] != ROW_PERIOD) bad++;
        check("row_period", 64'(bad), 64'd0);
        check("gb_count", 64'(gb_t.size()), 64'd2);
        if (gb_t.size() == 2 && fetch_t.size() == 65) begin
            check("gb_spacing", 64'(gb_t[1] - gb_t[0]), 64'(32 * ROW_PERIOD));
            check("gb_before_row0", 64'(gb_t[0] + 1), 64'(fetch_t[32]));
        end
        check("gb_r_enable_overlap", 64'(overlap), 64'd0);

        for (int r = 0; r < 3; r++) check_row(r, -1, -1);
        check_row(3, 40, -1);
        nf = fetch_t.size();
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (oe_n !== 1'b1) bad++;
        end
        check("drop_idle_no_fetch", 64'(fetch_t.size()), 64'(nf));
        check("drop_idle_dark", 64'(bad), 64'd0);
        check("drop_idle_cnt", 64'(row_0_sel), 64'd4);
        enable = 1'b1;
        for (int r = 4; r < 10; r++) check_row(r, -1, -1);
        check_row(10, -1, 5);
        check_row(0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
